// File: rtl/depth_pyr_down.sv
// depth_pyr_down: 2x2 depth pyramid downsampler with an invalid-depth (0) rule and a row-pair SRAM buffer.
// Optional PYR_ROUND_EN: round half-up on the 2x2 average instead of truncating.
package RgbdVoConfigPk;
   parameter int DATA_DEPTH_BW = 16;
   parameter int H_SIZE_BW     = 11;
   parameter int V_SIZE_BW     = 10;
endpackage

module depth_pyr_down
   import RgbdVoConfigPk::*;
(
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_frame_start,
   input  logic                     i_frame_end,
   input  logic                     i_valid,
   input  logic [DATA_DEPTH_BW-1:0] i_depth0,
   input  logic [H_SIZE_BW-1:0]     r_hsize,
   input  logic [V_SIZE_BW-1:0]     r_vsize,
   output logic                     o_sram_WENA,
   output logic [H_SIZE_BW-2:0]     o_sram_AA,
   output logic [H_SIZE_BW-2:0]     o_sram_AB,
   output logic [DATA_DEPTH_BW+1:0] o_sram_DA,
   input  logic [DATA_DEPTH_BW+1:0] i_sram_QB,
   output logic                     o_frame_start,
   output logic                     o_frame_end,
   output logic                     o_valid,
   output logic [DATA_DEPTH_BW-1:0] o_depth
);
   typedef enum logic {IDLE, ACTIVE} state_t;
   state_t r_state, w_state_nxt;
   logic [H_SIZE_BW-1:0]     r_x, w_px, w_x_nxt;
   logic [V_SIZE_BW-1:0]     r_y, w_py, w_y_nxt;
   logic                     w_acc, w_in, w_wr, w_rd, w_out, w_xw, w_yw, w_pflag;
   logic [DATA_DEPTH_BW-1:0] r_hold, r_depth, w_avg;
   logic                     r_rd_pend, r_valid, r_fs, r_fe;
   logic [DATA_DEPTH_BW+1:0] r_qb, w_qb, r_da, w_da, w_sum4, w_rnd;
   logic [H_SIZE_BW-2:0]     r_aa, r_ab;
   logic [DATA_DEPTH_BW:0]   w_psum;

   // a frame start makes the same-cycle pixel (0,0), whatever the counters held
   always_comb begin
      w_acc       = !i_rst && i_valid && (i_frame_start || r_state == ACTIVE);
      w_px        = i_frame_start ? '0 : r_x;
      w_py        = i_frame_start ? '0 : r_y;
      w_xw        = w_px == r_hsize - H_SIZE_BW'(1);
      w_yw        = w_py == r_vsize - V_SIZE_BW'(1);
      w_x_nxt     = w_acc ? (w_xw ? '0 : w_px + H_SIZE_BW'(1)) : w_px;
      w_y_nxt     = (w_acc && w_xw) ? (w_yw ? '0 : w_py + V_SIZE_BW'(1)) : w_py;
      w_state_nxt = i_frame_start ? ACTIVE : i_frame_end ? IDLE : r_state;
      w_in        = w_acc && ({w_px[H_SIZE_BW-1:1], 1'b1} < r_hsize)
                          && ({w_py[V_SIZE_BW-1:1], 1'b1} < r_vsize);
      w_psum      = {1'b0, r_hold} + {1'b0, i_depth0};
      w_pflag     = (r_hold == '0) || (i_depth0 == '0);
      w_da        = {w_pflag, w_psum};
      w_wr        = w_in && !w_py[0] && w_px[0];
      w_rd        = w_in && w_py[0] && !w_px[0];
      w_out       = w_in && w_py[0] && w_px[0];
      w_qb        = r_rd_pend ? i_sram_QB : r_qb;
      w_sum4      = {1'b0, w_qb[DATA_DEPTH_BW:0]} + {1'b0, w_psum};
`ifdef PYR_ROUND_EN
      w_rnd       = w_sum4 + (DATA_DEPTH_BW+2)'(2);
`else
      w_rnd       = w_sum4;
`endif
      w_avg       = DATA_DEPTH_BW'(w_rnd >> 2);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state   <= IDLE;
         r_x       <= '0;
         r_y       <= '0;
         r_hold    <= '0;
         r_rd_pend <= 1'b0;
         r_qb      <= '0;
         r_aa      <= '0;
         r_ab      <= '0;
         r_da      <= '0;
         r_valid   <= 1'b0;
         r_depth   <= '0;
         r_fs      <= 1'b0;
         r_fe      <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_x       <= w_x_nxt;
         r_y       <= w_y_nxt;
         if (w_acc && !w_px[0]) r_hold <= i_depth0;
         r_rd_pend <= w_rd;
         if (r_rd_pend) r_qb <= i_sram_QB;
         if (w_wr) begin
            r_aa <= w_px[H_SIZE_BW-1:1];
            r_da <= w_da;
         end
         if (w_rd) r_ab <= w_px[H_SIZE_BW-1:1];
         r_valid   <= w_out;
         if (w_out) r_depth <= (w_pflag || w_qb[DATA_DEPTH_BW+1]) ? '0 : w_avg;
         r_fs      <= i_frame_start;
         r_fe      <= i_frame_end;
      end
   end

   // SRAM ports are live in the pixel cycle so a read can follow a write of the same word
   assign o_sram_WENA   = !w_wr;
   assign o_sram_AA     = w_wr ? w_px[H_SIZE_BW-1:1] : r_aa;
   assign o_sram_DA     = w_wr ? w_da : r_da;
   assign o_sram_AB     = w_rd ? w_px[H_SIZE_BW-1:1] : r_ab;
   assign o_valid       = r_valid;
   assign o_depth       = r_depth;
   assign o_frame_start = r_fs;
   assign o_frame_end   = r_fe;
endmodule

// File: tb/tb_depth_pyr_down.sv
// tb_depth_pyr_down: randomized frames checked against a 2x2 block-average model with a behavioural SRAM.
module tb_depth_pyr_down;
   import RgbdVoConfigPk::*;
   logic clk = 1'b0;
   logic rst, fs, fe, vld;
   logic [DATA_DEPTH_BW-1:0] d0;
   logic [H_SIZE_BW-1:0]     hs;
   logic [V_SIZE_BW-1:0]     vs;
   logic                     wena;
   logic [H_SIZE_BW-2:0]     aa, ab;
   logic [DATA_DEPTH_BW+1:0] da, qb;
   logic                     o_fs, o_fe, o_vld;
   logic [DATA_DEPTH_BW-1:0] o_d;
   logic [DATA_DEPTH_BW+1:0] mem [0:(1<<(H_SIZE_BW-1))-1];
   logic [DATA_DEPTH_BW-1:0] pix [0:9][0:9];
   int n_cmp = 0, n_err = 0, wr_cnt = 0;

   always #5 clk = ~clk;

   depth_pyr_down dut (
      .i_clk(clk), .i_rst(rst), .i_frame_start(fs), .i_frame_end(fe), .i_valid(vld),
      .i_depth0(d0), .r_hsize(hs), .r_vsize(vs), .o_sram_WENA(wena), .o_sram_AA(aa),
      .o_sram_AB(ab), .o_sram_DA(da), .i_sram_QB(qb), .o_frame_start(o_fs),
      .o_frame_end(o_fe), .o_valid(o_vld), .o_depth(o_d)
   );

   always @(posedge clk) begin
      if (!wena) begin
         mem[aa] <= da;
         wr_cnt  <= wr_cnt + 1;
      end
      qb <= mem[ab];
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   function automatic logic [DATA_DEPTH_BW-1:0] blk(input int a, input int b, input int c, input int d);
      int s;
      if (a == 0 || b == 0 || c == 0 || d == 0) return '0;
      s = a + b + c + d;
`ifdef PYR_ROUND_EN
      s = s + 2;
`endif
      return DATA_DEPTH_BW'(s / 4);
   endfunction

   task automatic check_reset_outputs(input string tag);
      check({tag, "_valid"}, o_vld, 0);
      check({tag, "_depth"}, o_d, 0);
      check({tag, "_fs"}, o_fs, 0);
      check({tag, "_fe"}, o_fe, 0);
      check({tag, "_wena"}, wena, 1);
      check({tag, "_aa"}, aa, 0);
      check({tag, "_ab"}, ab, 0);
      check({tag, "_da"}, da, 0);
   endtask

   task automatic fill_random(input int w, input int h);
      for (int y = 0; y < h; y++)
         for (int x = 0; x < w; x++)
            pix[y][x] = ($urandom_range(0, 7) == 0) ? '0 : DATA_DEPTH_BW'($urandom);
   endtask

   task automatic drive_partial(input int w, input int n);
      for (int i = 0; i < n; i++) begin
         vld = 1'b1; d0 = pix[i / w][i % w]; fs = (i == 0);
         @(posedge clk); #1;
         vld = 1'b0; fs = 1'b0;
      end
   endtask

   task automatic run_frame(input int w, input int h, input int maxgap);
      logic [DATA_DEPTH_BW-1:0] eb [0:4][0:4];
      int nout, w0, ev, last;
      for (int by = 0; by < h / 2; by++)
         for (int bx = 0; bx < w / 2; bx++)
            eb[by][bx] = blk(pix[2*by][2*bx], pix[2*by][2*bx+1], pix[2*by+1][2*bx], pix[2*by+1][2*bx+1]);
      hs = H_SIZE_BW'(w); vs = V_SIZE_BW'(h);
      nout = 0; w0 = wr_cnt;
      for (int y = 0; y < h; y++)
         for (int x = 0; x < w; x++) begin
            if (x != 0 || y != 0)
               repeat ($urandom_range(0, maxgap)) begin
                  @(posedge clk); #1;
                  check("gap_valid", o_vld, 0);
                  check("gap_wena", wena, 1);
               end
            last = (x == w - 1) && (y == h - 1);
            vld = 1'b1; d0 = pix[y][x]; fs = (x == 0 && y == 0); fe = last[0];
            @(posedge clk); #1;
            vld = 1'b0; fs = 1'b0; fe = 1'b0;
            ev = (x % 2 == 1) && (y % 2 == 1) && (x < (w / 2) * 2) && (y < (h / 2) * 2);
            check("valid", o_vld, ev);
            if (ev) check("depth", o_d, eb[y / 2][x / 2]);
            nout += int'(o_vld);
            if (x == 0 && y == 0) check("frame_start", o_fs, 1);
            if (last != 0) check("frame_end", o_fe, 1);
         end
      check("n_outputs", nout, (w / 2) * (h / 2));
      check("n_writes", wr_cnt - w0, (w / 2) * (h / 2));
      @(posedge clk); #1;
      check("frame_end_pulse", o_fe, 0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; fs = 1'b0; fe = 1'b0; vld = 1'b0; d0 = '0; hs = '0; vs = '0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst = 1'b0;
      // fixed 4x2 frame: outputs 35 and 55 in either rounding mode
      pix[0][0:3] = '{16'd10, 16'd20, 16'd30, 16'd40};
      pix[1][0:3] = '{16'd50, 16'd60, 16'd70, 16'd80};
      run_frame(4, 2, 0);
      pix[0][0:1] = '{16'd1, 16'd2};
      pix[1][0:1] = '{16'd2, 16'd2};
      run_frame(2, 2, 0);
      pix[0][0:3] = '{16'd100, 16'd0, 16'd100, 16'd100};
      pix[1][0:3] = '{16'd100, 16'd100, 16'd100, 16'd100};
      run_frame(4, 2, 1);
      fill_random(5, 3);
      run_frame(5, 3, 0);
      fill_random(8, 4);
      run_frame(8, 4, 0);
      run_frame(8, 4, 7);
      // restart while a frame is in flight
      hs = 11'd8; vs = 10'd4;
      fill_random(8, 4);
      drive_partial(8, 11);
      fill_random(8, 4);
      run_frame(8, 4, 2);
      // reset in the middle of row 1, then stray pixels must be ignored
      hs = 11'd8; vs = 10'd4;
      fill_random(8, 4);
      drive_partial(8, 11);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check_reset_outputs("midreset");
      for (int i = 0; i < 4; i++) begin
         vld = 1'b1; d0 = 16'd7;
         @(posedge clk); #1;
         vld = 1'b0;
         check("idle_valid", o_vld, 0);
         check("idle_wena", wena, 1);
      end
      fill_random(8, 4);
      run_frame(8, 4, 3);
      for (int f = 0; f < 6; f++) begin
         int w, h;
         w = $urandom_range(2, 10); h = $urandom_range(2, 10);
         fill_random(w, h);
         run_frame(w, h, $urandom_range(0, 2));
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/depth_pyr_down.md
DEPTH_PYR_DOWN -- requirements
Module: depth_pyr_down

Interface
REQ-001 SHALL take params from RgbdVoConfigPk (DATA_DEPTH_BW, H_SIZE_BW, V_SIZE_BW); no local parameters.
REQ-002 SHALL have port i_clk, input, 1, sole clock.
REQ-003 SHALL have port i_rst, input, 1: one clock, reset synchronous and active-high.
REQ-004 SHALL have ports i_frame_start, i_frame_end, i_valid, input, 1: pixel stream from line buffer stage.
REQ-005 SHALL have port i_depth0, input, DATA_DEPTH_BW: depth pixel; value 0 = invalid depth.
REQ-006 SHALL have ports r_hsize (H_SIZE_BW) and r_vsize (V_SIZE_BW), input: full-resolution frame size.
REQ-007 SHALL have SRAM ports o_sram_WENA (1, active-low write), o_sram_AA and o_sram_AB (H_SIZE_BW-1), o_sram_DA (DATA_DEPTH_BW+2), input i_sram_QB (DATA_DEPTH_BW+2): row-pair buffer, port A write, port B read.
REQ-008 SHALL have outputs o_frame_start, o_frame_end, o_valid (1 each) and o_depth (DATA_DEPTH_BW): half-resolution stream.

Function
REQ-009 SHALL keep FSM IDLE/ACTIVE: IDLE->ACTIVE on i_frame_start; ACTIVE->IDLE on i_frame_end; i_valid ignored in IDLE.
REQ-010 SHALL keep counters x (0..r_hsize-1) and y (0..r_vsize-1); x increments per accepted i_valid, wraps at r_hsize-1 with y increment; y wraps at r_vsize-1.
REQ-011 SHALL zero x,y on i_frame_start; i_valid in the same cycle is pixel (0,0).
REQ-012 SHALL, on even y: hold pixel at even x; at odd x form pair sum (DATA_DEPTH_BW+1 bits) plus invalid flag (either pixel 0), write {flag,sum} to address x>>1 with o_sram_WENA=0 for that one cycle.
REQ-013 SHALL, on odd y at even x: drive o_sram_AB=x>>1; i_sram_QB valid exactly one cycle later.
REQ-014 SHALL, on odd y at odd x: combine current pair with i_sram_QB; 2x2 sum width DATA_DEPTH_BW+2; output 0 if any of 4 pixels is 0, else sum>>2 (see REQ-024).
REQ-015 SHALL register output: o_valid/o_depth asserted exactly 1 cycle after the i_valid of pixel (odd x, odd y).
REQ-016 SHALL drop trailing column when r_hsize odd and trailing row when r_vsize odd; no output, no SRAM write for them.
REQ-017 SHALL tolerate i_valid gaps of any length between pixels; held pixel and pending read data are retained (QB captured into register one cycle after read).
REQ-018 SHALL drive o_frame_start = i_frame_start delayed 1 cycle; o_frame_end = i_frame_end delayed 1 cycle, so it is never earlier than the last o_valid.
REQ-019 SHALL, on i_frame_start while ACTIVE, discard held pixel/partials and restart at (0,0); stale SRAM contents are overwritten before reuse.
REQ-020 SHALL drive o_sram_WENA=1 and o_valid=0 in all cycles not named above; o_sram_DA/AA/AB hold last value.

Reset
REQ-021 SHALL on i_rst high at a clock edge: FSM=IDLE, x=y=0, held pixel/flags cleared.
REQ-022 SHALL reset outputs: o_valid=0, o_depth=0, o_frame_start=0, o_frame_end=0, o_sram_WENA=1, o_sram_AA=0, o_sram_AB=0, o_sram_DA=0.
REQ-023 SHALL let reset mid-frame abort the frame; no output until next i_frame_start.

Configuration
REQ-024 SHALL honour macro PYR_ROUND_EN: defined -> o_depth=(sum+2)>>2 (round half-up); undefined -> o_depth=sum>>2 (truncate); invalid rule unchanged.

Verification
REQ-025 SHALL cover: hsize=4,vsize=2, rows {10,20,30,40},{50,60,70,80} -> two outputs 35,55 (both modes), o_valid 1 cycle after pixel (3,1) and (1,1).
REQ-026 SHALL cover: 2x2 block {1,2,2,2} -> 1 without PYR_ROUND_EN, 2 with it.
REQ-027 SHALL cover: one pixel 0 in a 2x2 block of 100s -> output 0; neighbouring all-100 block -> 100.
REQ-028 SHALL cover: hsize=5,vsize=3 -> exactly 2 outputs; column 4 and row 2 produce no SRAM write and no o_valid.
REQ-029 SHALL cover: random i_valid gaps of 0-7 cycles on a 8x4 frame -> outputs bit-identical to gap-free run.
REQ-030 SHALL cover: i_rst for 1 cycle mid-row 1, then new frame -> all outputs reset values, new frame results correct.
